delay_line_ctrl: RTL and testbench

Write/read sequencer that drives the dual-port sample memory as a circular delay buffer for the echo/delay effects. Per input audio sample it writes the sample at the write pointer and reads the sample written DELAY samples earlier. It returns that delayed sample with a one-cycle valid strobe. Sits between the audio sample path and the memory wrapper, on the memory's address/WE/data side.

---
 rtl/delay_line_ctrl_pkg.sv | 20 ++
 rtl/delay_line_ctrl_circ_ptr.sv | 28 ++
 rtl/delay_line_ctrl.sv | 151 +++++++++++++++
 tb/tb_delay_line_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and circular-address helpers for the delay line sequencer.
package delay_line_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StOut    = 2'd3
  } state_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned size);
    return (v >= size - 1) ? 0 : v + 1;
  endfunction

  function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned size);
    return (a >= b) ? a - b : a + size - b;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_circ_ptr.sv
// Circular pointer that wraps to zero after Size-1; synchronous active-high reset.
module delay_line_ctrl_circ_ptr
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned Width = 15,
  parameter int unsigned Size  = 20000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = Width'(wrap_inc(32'(ptr_q), Size));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// Write/read sequencer running the sample memory as a circular delay buffer:
// one write plus one delayed read per accepted sample.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 31,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned SIZE       = 20000,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] SAMPLE_IN,
  input  logic                  SAMPLE_VALID,
  input  logic [ADDR_WIDTH-1:0] DELAY,
  output logic [DATA_WIDTH-1:0] SAMPLE_OUT,
  output logic                  OUT_VALID,
  output logic                  BUSY,
  output logic                  OVERRUN,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_WADDR,
  output logic [ADDR_WIDTH-1:0] MEM_RADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

  localparam int unsigned FillW = $clog2(SIZE + 1);
  localparam int unsigned CntW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] DMax    = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   SizeExt = (ADDR_WIDTH + 1)'(SIZE);

  state_e                  state_d, state_q;
  logic [DATA_WIDTH-1:0]   sample_d, sample_q;
  logic [DATA_WIDTH-1:0]   sample_out_d, sample_out_q;
  logic [ADDR_WIDTH-1:0]   d_d, d_q;
  logic [ADDR_WIDTH-1:0]   raddr_d, raddr_q;
  logic [CntW-1:0]         cnt_d, cnt_q;
  logic [FillW-1:0]        fill_d, fill_q;
  logic                    overrun_d, overrun_q;
  logic [ADDR_WIDTH-1:0]   wptr;
  logic                    wptr_inc;
  logic [ADDR_WIDTH:0]     wp_ext, d_ext, raddr_ext;
  logic [ADDR_WIDTH-1:0]   raddr_calc;
  logic [DATA_WIDTH-1:0]   out_val;
  logic                    unused_raddr_msb;

  delay_line_ctrl_circ_ptr #(
    .Width (ADDR_WIDTH),
    .Size  (SIZE)
  ) u_wptr (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (wptr_inc),
    .ptr_o (wptr)
  );

  // Read address trails the write pointer by d, computed one bit wider to avoid underflow.
  always_comb begin
    wp_ext = {1'b0, wptr};
    d_ext  = {1'b0, d_q};
    if (wp_ext >= d_ext) raddr_ext = wp_ext - d_ext;
    else                 raddr_ext = wp_ext + SizeExt - d_ext;
    raddr_calc       = raddr_ext[ADDR_WIDTH-1:0];
    unused_raddr_msb = raddr_ext[ADDR_WIDTH];
  end

  // Zero until d samples exist; d==0 bypasses the RAM to dodge the same-address hazard.
  always_comb begin
    if (32'(fill_q) < 32'(d_q)) out_val = '0;
    else if (d_q == '0)         out_val = sample_q;
    else                        out_val = MEM_RDATA;
  end

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    sample_out_d = sample_out_q;
    d_d          = d_q;
    raddr_d      = raddr_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    overrun_d    = overrun_q | (SAMPLE_VALID && (state_q != StIdle));
    wptr_inc     = 1'b0;
    SAMPLE_OUT   = sample_out_q;
    OUT_VALID    = 1'b0;
    MEM_WE       = 1'b0;
    MEM_WADDR    = '0;
    MEM_RADDR    = '0;
    MEM_WDATA    = '0;

    unique case (state_q)
      StIdle: begin
        if (SAMPLE_VALID) begin
          sample_d = SAMPLE_IN;
          d_d      = (32'(DELAY) >= SIZE) ? DMax : DELAY;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        MEM_WE    = 1'b1;
        MEM_WADDR = wptr;
        MEM_WDATA = sample_q;
        MEM_RADDR = raddr_calc;
        raddr_d   = raddr_calc;
        cnt_d     = CntW'(RD_LAT - 1);
        state_d   = StWait;
      end
      StWait: begin
        MEM_RADDR = raddr_q;
        if (cnt_q == '0) state_d = StOut;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StOut: begin
        MEM_RADDR    = raddr_q;
        OUT_VALID    = 1'b1;
        SAMPLE_OUT   = out_val;
        sample_out_d = out_val;
        wptr_inc     = 1'b1;
        if (32'(fill_q) != SIZE) fill_d = fill_q + 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign BUSY    = (state_q != StIdle);
  assign OVERRUN = overrun_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      sample_out_q <= '0;
      d_q          <= '0;
      raddr_q      <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      sample_out_q <= sample_out_d;
      d_q          <= d_d;
      raddr_q      <= raddr_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: small buffer (SIZE=8), behavioural RAM and a sample-history model.
module tb_delay_line_ctrl;

  localparam int unsigned DW = 31;
  localparam int unsigned AW = 5;
  localparam int unsigned SZ = 8;
  localparam int unsigned RL = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] SAMPLE_IN;
  logic          SAMPLE_VALID;
  logic [AW-1:0] DELAY;
  logic [DW-1:0] SAMPLE_OUT;
  logic          OUT_VALID;
  logic          BUSY;
  logic          OVERRUN;
  logic          MEM_WE;
  logic [AW-1:0] MEM_WADDR;
  logic [AW-1:0] MEM_RADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  delay_line_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SIZE       (SZ),
    .RD_LAT     (RL)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SAMPLE_IN    (SAMPLE_IN),
    .SAMPLE_VALID (SAMPLE_VALID),
    .DELAY        (DELAY),
    .SAMPLE_OUT   (SAMPLE_OUT),
    .OUT_VALID    (OUT_VALID),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN),
    .MEM_WE       (MEM_WE),
    .MEM_WADDR    (MEM_WADDR),
    .MEM_RADDR    (MEM_RADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_RDATA    (MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Two-stage registered read, stale random contents to expose any unmasked reads.
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] rd_p1, rd_p2;
  initial for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_WADDR] <= MEM_WDATA;
    rd_p1 <= mem[MEM_RADDR];
    rd_p2 <= rd_p1;
  end
  assign MEM_RDATA = rd_p2;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] hist[$];
  bit ovr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"},    32'(SAMPLE_OUT), 0);
    chk({tag, "_valid"},  32'(OUT_VALID), 0);
    chk({tag, "_busy"},   32'(BUSY), 0);
    chk({tag, "_ovr"},    32'(OVERRUN), 0);
    chk({tag, "_we"},     32'(MEM_WE), 0);
    chk({tag, "_waddr"},  32'(MEM_WADDR), 0);
    chk({tag, "_raddr"},  32'(MEM_RADDR), 0);
    chk({tag, "_wdata"},  32'(MEM_WDATA), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    SAMPLE_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;
    hist.delete();
    ovr_m = 1'b0;
  endtask

  // Expected output: the sample accepted d samples earlier since reset, else zero.
  task automatic run_sample(input logic [DW-1:0] s, input int unsigned dly, input bit ovr);
    int unsigned d, n, w, r;
    logic [DW-1:0] exp;
    d   = (dly >= SZ) ? SZ - 1 : dly;
    n   = hist.size();
    exp = (n < d) ? '0 : ((d == 0) ? s : hist[n - d]);
    w   = n % SZ;
    r   = (w + SZ - d) % SZ;
    SAMPLE_IN = s;
    DELAY = AW'(dly);
    SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    SAMPLE_IN = DW'($urandom);
    DELAY = AW'($urandom);
    chk("access_we",    32'(MEM_WE), 1);
    chk("access_waddr", 32'(MEM_WADDR), w);
    chk("access_wdata", 32'(MEM_WDATA), 32'(s));
    chk("access_raddr", 32'(MEM_RADDR), r);
    chk("access_busy",  32'(BUSY), 1);
    chk("access_valid", 32'(OUT_VALID), 0);
    for (int i = 0; i < int'(RL); i++) begin
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
      chk("wait_we",    32'(MEM_WE), 0);
      chk("wait_valid", 32'(OUT_VALID), 0);
      chk("wait_raddr", 32'(MEM_RADDR), r);
      if (ovr && i == 0) begin
        SAMPLE_VALID = 1'b1;
        SAMPLE_IN = DW'($urandom);
        ovr_m = 1'b1;
      end
    end
    @(negedge CLK);
    chk("out_valid", 32'(OUT_VALID), 1);
    chk("out_data",  32'(SAMPLE_OUT), 32'(exp));
    chk("out_we",    32'(MEM_WE), 0);
    chk("out_busy",  32'(BUSY), 1);
    @(negedge CLK);
    chk("post_valid", 32'(OUT_VALID), 0);
    chk("post_hold",  32'(SAMPLE_OUT), 32'(exp));
    chk("post_busy",  32'(BUSY), 0);
    chk("post_ovr",   32'(OVERRUN), 32'(ovr_m));
    hist.push_back(s);
  endtask

  initial begin
    RST = 1'b1;
    SAMPLE_IN = '0;
    SAMPLE_VALID = 1'b0;
    DELAY = '0;
    ovr_m = 1'b0;
    do_reset();

    for (int i = 1; i <= 5; i++) run_sample(DW'(10 * i), 3, 1'b0);
    run_sample(DW'('h55), 0, 1'b0);

    do_reset();
    for (int i = 1; i <= 10; i++) run_sample(DW'(i), 2, 1'b0);

    do_reset();
    for (int i = 0; i < 9; i++) run_sample(DW'(100 + i), 20, 1'b0);

    run_sample(DW'('h1234), 1, 1'b1);
    run_sample(DW'('h4321), 1, 1'b0);

    // Reset while the sample is waiting on the read: it must vanish without a strobe.
    SAMPLE_IN = DW'('h777);
    DELAY = AW'(1);
    SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("midrst");
    RST = 1'b0;
    hist.delete();
    ovr_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("midrst_novalid", 32'(OUT_VALID), 0);
    end
    run_sample(DW'('h99), 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_sample(DW'($urandom), $urandom_range(0, 12), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
